// File: rtl/i2c_tx_seq.sv
// I2C transmit sequencer: a show-ahead TX FIFO feeding an I2C master byte by
// byte. A transaction is armed with go/len, waits until enough bytes are
// buffered, then holds START high while the master consumes bytes on
// data_vld rising edges.
module i2c_tx_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  input  logic              go,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              ovf,
  output logic              START,
  output logic [LEN_W-1:0]  num_bytes,
  output logic [DATA_W-1:0] tx_data,
  input  logic              data_vld
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      rd_q, wr_q;
  logic [AW:0]        lvl_q;
  logic [LEN_W-1:0]   rem_q, rem_d, nb_q, nb_d;
  logic               vld_q, start_q, ovf_q, lerr_q;
  logic               pop, push, ovf_d, lerr_d;

  assign full      = (lvl_q == (AW+1)'(DEPTH));
  assign empty     = (lvl_q == '0);
  assign level     = lvl_q;
  assign tx_data   = mem[rd_q];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign START     = start_q;
  assign num_bytes = nb_q;
  assign ovf       = ovf_q;
  assign len_err   = lerr_q;

  // Pops only happen in RUN on a data_vld rising edge; a pop frees a slot so a
  // push in the same cycle is accepted even when full. Abort cancels both.
  assign pop   = (state_q == RUN) && data_vld && !vld_q && !abort;
  assign push  = wr_en && (!full || pop) && !abort;
  assign ovf_d = wr_en && full && !pop && !abort;

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    nb_d    = nb_q;
    lerr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && len != '0) begin
          if (32'(len) > DEPTH) begin
            lerr_d = 1'b1;
          end else begin
            nb_d    = len;
            rem_d   = len;
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: if (32'(lvl_q) >= 32'(rem_q)) state_d = RUN;
      RUN: begin
        if (pop) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      lerr_d  = 1'b0;
    end
  end

  // FSM, transaction counters and registered status pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
      nb_q    <= '0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      nb_q    <= nb_d;
      vld_q   <= data_vld;
      start_q <= (state_d == RUN);
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  // FIFO pointers and occupancy; abort flushes everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else if (abort) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      lvl_q <= lvl_q + 1'b1;
      else if (pop && !push) lvl_q <= lvl_q - 1'b1;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_q] <= wr_data;
  end

endmodule
